// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter: round-robin owner of the shared uio pad bus with turnaround and tenure limit
module uio_bus_arbiter #(
  parameter int NREQ = 4,
  parameter int TURN_CYC = 1,
  parameter int MAX_HOLD = 16,
  parameter logic [7:0] OE_MASK = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   dir,
  input  logic [8*NREQ-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [7:0]        rdata,
  output logic              rvalid,
  input  logic [7:0]        uio_in,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe
);
  localparam int IW = $clog2(NREQ);
  localparam int HW = $clog2(MAX_HOLD);
  typedef enum logic [1:0] {IDLE, TURN, OWN} state_t;
  state_t state, nxt;
  logic [IW-1:0] rr_ptr, own, win;
  logic [HW-1:0] hold_cnt;
  logic [2:0] turn_cnt;
  logic own_dir, turn_done, hold_max, stay, grant;
  assign turn_done = turn_cnt == 3'(TURN_CYC - 1);
  assign hold_max = hold_cnt == HW'(MAX_HOLD - 1);
  assign stay = state == OWN && nxt == OWN;
  assign grant = state == TURN && nxt == OWN;
  // round-robin winner: lowest requester above rr_ptr, else lowest overall
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[i]) win = IW'(i);
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[i] && i > int'(rr_ptr)) win = IW'(i);
  end
  // next state: ena low always releases; owner leaves on drop or preemption at tenure limit
  always_comb
    nxt = !ena ? IDLE :
          state == IDLE ? (|req ? TURN : IDLE) :
          state == TURN ? (!turn_done ? TURN : |req ? OWN : IDLE) :
          (!req[own] || (hold_max && |(req & ~gnt))) ? TURN : OWN;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // registered outputs and tenure bookkeeping; pads only driven after the first owned cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gnt <= '0;
      uio_oe <= '0;
      uio_out <= '0;
      rdata <= '0;
      rvalid <= 1'b0;
      rr_ptr <= IW'(NREQ - 1);
      own <= '0;
      own_dir <= 1'b0;
      hold_cnt <= '0;
      turn_cnt <= '0;
    end else begin
      gnt <= grant ? NREQ'(1) << win : stay ? gnt : '0;
      uio_oe <= stay && own_dir ? OE_MASK : 8'h00;
      if (stay && own_dir) uio_out <= wdata[8*own+:8];
      if (stay && !own_dir) rdata <= uio_in;
      rvalid <= stay && !own_dir;
      if (grant) begin
        rr_ptr <= win;
        own <= win;
        own_dir <= dir[win];
      end
      hold_cnt <= state != OWN ? '0 : hold_max ? hold_cnt : hold_cnt + 1'b1;
      turn_cnt <= state == TURN ? turn_cnt + 1'b1 : '0;
    end
endmodule

// File: tb/tb_uio_bus_arbiter.sv
// tb_uio_bus_arbiter: scoreboard bench with a cycle-level behavioural model of the arbiter
module tb_uio_bus_arbiter;
  localparam int NREQ = 4;
  localparam int TURN_CYC = 1;
  localparam int MAX_HOLD = 16;
  localparam logic [7:0] OE_MASK = 8'hFF;
  logic clk = 0;
  logic rst_n = 1;
  logic ena;
  logic [NREQ-1:0] req, dir, gnt;
  logic [8*NREQ-1:0] wdata;
  logic [7:0] rdata, uio_in, uio_out, uio_oe;
  logic rvalid;
  int errors = 0;
  int checks = 0;
  typedef struct {logic [NREQ-1:0] g; logic [7:0] oe, out, rd; logic rv;} exp_t;
  exp_t q[$];
  int gq[$];
  uio_bus_arbiter #(.NREQ(NREQ), .TURN_CYC(TURN_CYC), .MAX_HOLD(MAX_HOLD), .OE_MASK(OE_MASK)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req(req), .dir(dir), .wdata(wdata),
    .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // reference model: phase 0 idle, 1 turnaround, 2 owned; age counts owned cycles so far
  int m_ph, m_owner, m_ptr, m_age, m_left;
  bit m_wr;
  logic [NREQ-1:0] e_gnt;
  logic [7:0] e_oe, e_out, e_rd;
  logic e_rv;
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_ph = 0; m_owner = -1; m_ptr = NREQ - 1; m_age = 0; m_left = 0; m_wr = 0;
      e_gnt = 0; e_oe = 0; e_out = 0; e_rd = 0; e_rv = 0;
      q.delete();
      gq.delete();
    end else begin
      if (!ena) begin
        m_ph = 0; e_gnt = 0; e_oe = 0; e_rv = 0;
      end else if (m_ph == 0) begin
        if (req != 0) begin m_ph = 1; m_left = TURN_CYC; end
      end else if (m_ph == 1) begin
        m_left--;
        if (m_left == 0) begin
          m_owner = -1;
          for (int k = 1; k <= NREQ; k++)
            if (m_owner < 0 && req[(m_ptr + k) % NREQ]) m_owner = (m_ptr + k) % NREQ;
          if (m_owner < 0) m_ph = 0;
          else begin
            m_ph = 2; m_ptr = m_owner; m_age = 1; m_wr = dir[m_owner];
            e_gnt = NREQ'(1 << m_owner);
            gq.push_back(m_owner);
          end
        end
      end else if (!req[m_owner] || (m_age == MAX_HOLD && (req & ~(1 << m_owner)) != 0)) begin
        m_ph = 1; m_left = TURN_CYC; e_gnt = 0; e_oe = 0; e_rv = 0;
      end else begin
        if (m_age < MAX_HOLD) m_age++;
        if (m_wr) begin e_oe = OE_MASK; e_out = wdata[8*m_owner+:8]; end
        else begin e_rd = uio_in; e_rv = 1; end
      end
      q.push_back('{e_gnt, e_oe, e_out, e_rd, e_rv});
    end
  end
  // monitor: compares every presented cycle and every new grant against the queues
  logic [NREQ-1:0] prev_gnt;
  initial forever begin
    @(negedge clk);
    if (!rst_n) prev_gnt = 0;
    else begin
      exp_t e;
      chk("onehot", int'($countones(gnt) <= 1), 1);
      if (gnt != 0 && gnt != prev_gnt) begin
        chk("grant_expected", int'(gq.size() > 0), 1);
        if (gq.size() > 0) chk("grant_order", gnt, 1 << gq.pop_front());
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("gnt", gnt, e.g);
        chk("uio_oe", uio_oe, e.oe);
        chk("uio_out", uio_out, e.out);
        chk("rvalid", rvalid, e.rv);
        chk("rdata", rdata, e.rd);
      end
      prev_gnt = gnt;
    end
  end
  task automatic wait_gnt(input logic [NREQ-1:0] g, input string nm);
    int n = 0;
    while (gnt != g && n < 100) begin @(negedge clk); n++; end
    chk(nm, gnt, g);
  endtask
  initial begin
    int n;
    logic [NREQ-1:0] g;
    ena = 1; req = 0; dir = 0; wdata = 0; uio_in = 0;
    #2 rst_n = 0;
    #1 chk("rst_gnt", gnt, 0); chk("rst_oe", uio_oe, 0); chk("rst_out", uio_out, 0);
    chk("rst_rdata", rdata, 0); chk("rst_rvalid", rvalid, 0);
    @(negedge clk); #1 rst_n = 1;
    @(posedge clk); #1 req = 4'b0001; dir = 4'b0001; wdata[7:0] = 8'hA5;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("lat_gnt", gnt, 1); chk("lat_oe_first", uio_oe, 0);
    @(negedge clk);
    chk("lat_oe", uio_oe, 8'hFF); chk("lat_out", uio_out, 8'hA5);
    @(posedge clk); #2 rst_n = 0;
    #1 chk("async_gnt", gnt, 0); chk("async_oe", uio_oe, 0); chk("async_rvalid", rvalid, 0);
    req = 4'b1111; dir = 4'b1010; wdata = $urandom;
    @(negedge clk); #1 rst_n = 1;
    @(negedge clk);
    for (int t = 0; t < 5; t++) begin
      n = 0;
      while (gnt == 0 && n < 50) begin @(negedge clk); n++; end
      if (t > 0) chk("turn_gap", n, 1);
      chk("rr_order", gnt, 1 << (t % NREQ));
      g = gnt; n = 0;
      while (gnt == g && n < 100) begin @(negedge clk); n++; end
      chk("tenure_len", n, MAX_HOLD);
    end
    @(posedge clk); #1 req = 4'b0100; dir = 4'b0000; uio_in = 8'h3C;
    wait_gnt(4'b0100, "read_gnt");
    chk("read_rvalid_first", rvalid, 0);
    @(negedge clk);
    chk("read_rvalid", rvalid, 1); chk("read_rdata", rdata, 8'h3C);
    @(posedge clk); #1 req = 0;
    @(negedge clk); @(negedge clk);
    chk("drop_gnt", gnt, 0); chk("drop_rvalid", rvalid, 0); chk("drop_rdata_held", rdata, 8'h3C);
    @(posedge clk); #1 req = 4'b0010; dir = 4'b0010; wdata = 32'h0000_5A00;
    wait_gnt(4'b0010, "single_gnt");
    n = 0;
    repeat (100) begin @(negedge clk); if (gnt != 4'b0010) n++; end
    chk("single_hold", n, 0);
    @(posedge clk); #1 ena = 0;
    @(negedge clk); @(negedge clk);
    chk("ena_gnt", gnt, 0); chk("ena_oe", uio_oe, 0); chk("ena_out_held", uio_out, 8'h5A);
    @(posedge clk); #1 ena = 1;
    @(posedge clk); @(negedge clk);
    chk("ena_turn", gnt, 0);
    @(negedge clk);
    chk("ena_regrant", gnt, 4'b0010);
    repeat (600) begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) if ($urandom_range(0, 15) == 0) req[i] = ~req[i];
      dir = NREQ'($urandom); wdata = $urandom; uio_in = 8'($urandom);
      ena = $urandom_range(0, 39) != 0;
    end
    @(posedge clk); #1 req = 0; ena = 1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
